// File: rtl/p5_mem_pkg.sv
// Shared memory-side types for the MEM stage / data-memory path.
package p5_mem_pkg;

  localparam int unsigned DM_AW = 10;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic             valid;
    logic [DM_AW-1:0] addr;
    word_t            data;
  } sb_entry_t;

endpackage

// File: rtl/store_buf_fwd.sv
// Store-buffer forwarding: finds the youngest valid entry whose address
// matches the load address.
module store_buf_fwd
  import p5_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [PW:0]      count,
  input  logic [DM_AW-1:0] ld_addr,
  output logic             hit,
  output word_t            data
);

  // Walks oldest to youngest and lets later matches override earlier ones.
  // The result equals a tail-1 backwards priority scan.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && entries[idx].valid &&
          (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer between the MEM stage and the data memory.
// Stores are queued and retired one per cycle while no load uses the DM port;
// loads hitting buffered words are forwarded from the youngest match.
module dm_store_buffer
  import p5_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [31:0]   ld_data,
  output logic          ld_hit,
  output logic          empty,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          dm_we,
  input  logic [31:0]   dm_dout
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic  full;
  logic  do_enq;
  logic  do_drain;
  logic  fwd_hit;
  word_t fwd_data;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign do_enq   = st_valid && st_ready;
  assign do_drain = !ld_valid && !empty;

  store_buf_fwd #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .ld_addr (DM_AW'(ld_addr)),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  // Load result and DM port muxing: a load owns the port, otherwise drain head.
  always_comb begin
    ld_hit  = ld_valid && fwd_hit;
    ld_data = ld_hit ? fwd_data : dm_dout;
    dm_din  = entries_q[head_q].data;
    dm_we   = do_drain;
    dm_addr = ld_valid ? ld_addr : AW'(entries_q[head_q].addr);
  end

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (do_enq) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = DM_AW'(st_addr);
      entries_d[tail_q].data  = st_data;
      tail_d                  = tail_q + PW'(1);
    end
    if (do_drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1);
    end
    case ({do_enq, do_drain})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all pending stores.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer between the MEM stage and the data memory (DM). Accepted stores are queued in a small in-order FIFO and retired into DM one word per cycle whenever the MEM stage is not using the DM port for a load. Loads to a word that is still buffered are forwarded from the youngest matching entry, so the pipeline always sees program-order memory state. The block owns the DM port outright: DM's address, write-data and write-enable are driven only from here.

## Interface
Parameters:
- DEPTH, 4: number of buffer entries; power of two, at least 2.
- AW, 10: word-address width, matching DM's addr[11:2].

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  MEM stage presents a word store this cycle.
- st_addr  in  AW  word address of the store.
- st_data  in  32  store data.
- st_ready  out  1  buffer can accept a store this cycle; equals !full.
- ld_valid  in  1  MEM stage performs a load this cycle.
- ld_addr  in  AW  word address of the load.
- ld_data  out  32  load result, either forwarded or taken from dm_dout.
- ld_hit  out  1  ld_data came from the buffer.
- empty  out  1  no pending stores.
- dm_addr  out  AW  DM address.
- dm_din  out  32  DM write data.
- dm_we  out  1  DM write enable.
- dm_dout  in  32  DM combinational read data.

## Operation
- **Storage:** circular FIFO of DEPTH {addr, data, valid} entries.
  - head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - full is count==DEPTH; empty is count==0.
- **Enqueue:** happens on st_valid && st_ready. The entry is written at tail, then tail and count increment.
- **Drain:** occurs in any cycle with !ld_valid && !empty.
  - dm_we=1, dm_addr=head.addr, dm_din=head.data.
  - At the edge, DM writes the word, the head entry is invalidated, head increments and count decrements.
- **Load:** occurs in any cycle with ld_valid.
  - dm_addr=ld_addr and dm_we=0; no drain happens.
  - ld_addr is compared against every valid entry.
  - On a hit, ld_hit=1 and ld_data is the data of the youngest matching entry (closest to tail).
  - On a miss, ld_hit=0 and ld_data=dm_dout.
- **Port idle:** when !ld_valid && empty, dm_we=0 and dm_addr/dm_din follow the head entry, which is 0 after reset.
- **Multiple stores to one address:** stores to the same address are never coalesced. Each one is drained separately, in order.
- **Same-cycle store and load:** if st_valid and ld_valid are both high in one cycle, the load sees only entries accepted before that cycle.
- **Full with drain in the same cycle:** st_ready stays 0 (it is based on registered count). The store is accepted next cycle.
- **Load starvation:** back-to-back loads stall draining indefinitely. The pipeline must use empty to quiesce the buffer, e.g. before a syscall/eret.

## Timing
- **Reset:** while reset_n=0, asynchronously and independently of clk:
  - head=tail=count=0 and all valid bits are cleared; entry addr/data are cleared to 0.
  - st_ready=1, empty=1, dm_we=0, ld_hit=0, dm_addr=0, dm_din=0.
  - ld_data=dm_dout.
  - Pending stores are discarded and never reach DM.
- **Store-to-DM latency:** a store accepted at edge N is driven with dm_we=1 during cycle N+1 at the earliest, and is committed to DM at edge N+1.
- **Throughput:** one enqueue and one drain per cycle, concurrently allowed.
- **Combinational outputs:** ld_data, ld_hit and dm_* are combinational from registered state plus ld_valid/ld_addr. There is no extra load latency; DM's read is combinational.
- **Registered outputs:** st_ready and empty are registered-state functions only, with no combinational path from st_valid.

## Structure
- **Shared package p5_mem_pkg:**
  - DM_AW=10.
  - word_t as a 32-bit type.
  - sb_entry_t struct {valid, addr[DM_AW-1:0], data word_t}.
- **Sub-module store_buf_fwd:** combinational youngest-match finder.
  - Inputs: the entry array, head, count, ld_addr.
  - Outputs: hit and the matched data.
  - It scans from tail-1 backwards with a wrap-aware priority.
- The top level holds the pointers, the counter, entry registers and DM port muxing.

## Test plan
- **Reset:** pulse reset_n low mid-cycle -> immediately st_ready=1, empty=1, dm_we=0, ld_hit=0, dm_addr=0.
- **Single store:** store 0x12345678 to 0x004 with ld_valid=0 -> next cycle dm_we=1, dm_addr=0x004, dm_din=0x12345678; the cycle after, empty=1 and DM word 0x004 reads back 0x12345678.
- **Fill:** with ld_valid held 1, store 0x1..0x4 to 0x010..0x013 -> st_ready=0 after the 4th; a 5th st_valid is held off. Drop ld_valid -> dm_we for 4 consecutive cycles, addresses 0x010..0x013 in order. st_ready=1 one cycle after the first drain.
- **Forwarding:** with loads active, store 0xA then 0xB to 0x020; load 0x020 -> ld_hit=1, ld_data=0xB. Load 0x021 -> ld_hit=0, ld_data=dm_dout.
- **Wrap-around:** perform 10 interleaved stores and drains so that head and tail wrap twice -> every word lands in DM in program order, and count never exceeds 4.
- **Reset mid-operation:** with 3 stores pending, assert reset_n=0 asynchronously -> dm_we=0 at once, empty=1, and those 3 words are never written to DM.
